bias_group_scheduler: RTL and testbench

- Sequences bias addition for one conv layer whose adder-tree output is N_ADDER_TREE lanes × 18-bit signed fixed point.
- Receives a flat bank of N_GROUPS bias vectors, one per output-channel group, from the constant BIAS_layer* generators.
- Selects the active group's vector, adds it with saturation to each incoming adder-tree beat, streams results downstream with valid/ready, and advances groups after a programmed pixel count.
- Sits between the adder tree and the activation/write-back stage.

---
 rtl/bias_sched_pkg.sv | 20 ++
 rtl/bias_sat_add_lane.sv | 34 +++
 rtl/bias_group_scheduler.sv | 120 ++++++++++++
 tb/tb_bias_group_scheduler.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bias_sched_pkg.sv
// Shared types and constants for the conv-layer bias group scheduler.
package bias_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int DATA_W_DEF = 18;

  localparam logic [DATA_W_DEF-1:0] SAT_MAX = 18'h1FFFF;
  localparam logic [DATA_W_DEF-1:0] SAT_MIN = 18'h20000;

  // Bit offset of a lane inside a flat lane-packed bus.
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction

endpackage

// File: rtl/bias_sat_add_lane.sv
// One lane of bias addition: (DATA_W+1)-bit signed add, saturate to DATA_W,
// optional ReLU when BIAS_RELU_EN is defined.
module bias_sat_add_lane
  import bias_sched_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y
);

  localparam logic [DATA_W-1:0] MAX_V = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_V = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] sat;

  always_comb begin
    // NOTE: sat gets an unconditional default before the override, so no latch is inferred.
    sum = {a[DATA_W-1], a} + {b[DATA_W-1], b};
    sat = sum[DATA_W-1:0];
    // The two top bits disagree only on overflow; the extra sign bit tells the direction.
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat = sum[DATA_W] ? MIN_V : MAX_V;
    end
`ifdef BIAS_RELU_EN
    y = sat[DATA_W-1] ? '0 : sat;
`else
    y = sat;
`endif
  end

endmodule

// File: rtl/bias_group_scheduler.sv
// Adds the active group's bias vector to each adder-tree beat with saturation and
// advances groups every pix_per_group beats. Define BIAS_RELU_EN to clamp negatives to 0.
module bias_group_scheduler
  import bias_sched_pkg::*;
#(
  parameter int N_ADDER_TREE = 16,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int N_GROUPS     = 8,
  parameter int PIX_W        = 16,
  localparam int GRP_W       = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 start,
  input  logic [PIX_W-1:0]                     pix_per_group,
  input  logic [N_GROUPS*N_ADDER_TREE*DATA_W-1:0] bias_bank,
  input  logic                                 in_valid,
  output logic                                 in_ready,
  input  logic [N_ADDER_TREE*DATA_W-1:0]       in_data,
  output logic                                 out_valid,
  input  logic                                 out_ready,
  output logic [N_ADDER_TREE*DATA_W-1:0]       out_data,
  output logic [GRP_W-1:0]                     out_group,
  output logic                                 out_last,
  output logic                                 busy,
  output logic                                 done
);

  localparam int VEC_W = N_ADDER_TREE * DATA_W;
  localparam logic [GRP_W-1:0] GRP_LAST = GRP_W'(N_GROUPS - 1);

  state_t           state;
  logic [PIX_W-1:0] ppg;
  logic [PIX_W-1:0] pix;
  logic [GRP_W-1:0] grp;

  logic [VEC_W-1:0] bias_sel;
  logic [VEC_W-1:0] sum_vec;
  logic             stall;
  logic             in_fire;
  logic             pix_wrap;
  logic             beat_last;

  assign bias_sel  = bias_bank[int'(grp)*VEC_W +: VEC_W];
  // Single output register with no skid: a held result blocks the input.
  assign stall     = out_valid & ~out_ready;
  assign in_ready  = (state == RUN) & ~stall;
  assign in_fire   = in_valid & in_ready;
  assign pix_wrap  = (pix == ppg - 1'b1);
  assign beat_last = pix_wrap & (grp == GRP_LAST);

  for (genvar k = 0; k < N_ADDER_TREE; k++) begin : g_lane
    bias_sat_add_lane #(
      .DATA_W(DATA_W)
    ) u_lane (
      .a(in_data[lane_lsb(k, DATA_W) +: DATA_W]),
      .b(bias_sel[lane_lsb(k, DATA_W) +: DATA_W]),
      .y(sum_vec[lane_lsb(k, DATA_W) +: DATA_W])
    );
  end

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every read sees pre-edge values.
    if (rst) begin
      state     <= IDLE;
      ppg       <= '0;
      pix       <= '0;
      grp       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_group <= '0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;

      // A departing beat and an arriving one may share the same edge.
      if (out_valid && out_ready) out_valid <= 1'b0;
      if (in_fire) begin
        out_valid <= 1'b1;
        out_data  <= sum_vec;
        out_group <= grp;
        out_last  <= beat_last;
      end

      case (state)
        IDLE: begin
          if (start) begin
            ppg   <= (pix_per_group == '0) ? PIX_W'(1) : pix_per_group;
            pix   <= '0;
            grp   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (in_fire) begin
            if (pix_wrap) begin
              pix <= '0;
              grp <= beat_last ? '0 : grp + 1'b1;
            end else begin
              pix <= pix + 1'b1;
            end
            if (beat_last) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_valid && out_ready && out_last) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bias_group_scheduler.sv
// Self-checking bench: beat-level reference model plus directed scenarios with literal expectations.
module tb_bias_group_scheduler;

  localparam int N  = 4;
  localparam int W  = 18;
  localparam int G  = 2;
  localparam int PW = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [PW-1:0]    pix_per_group = '0;
  logic [G*N*W-1:0] bias_bank;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [N*W-1:0]   in_data = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [N*W-1:0]   out_data;
  logic [0:0]       out_group;
  logic             out_last;
  logic             busy;
  logic             done;

  // group1 {lane3..lane0}, group0 {lane3..lane0}
  assign bias_bank = {18'h3FFF9, 18'h3FF00, 18'h00200, 18'h00123,
                      18'h00005, 18'h3FF00, 18'h00200, 18'h3F510};

  // The same biases as plain integers, indexed [group][lane].
  int bias_tab [G][N] = '{'{-2800, 512, -256, 5}, '{291, 512, -256, -7}};

  bias_group_scheduler #(
    .N_ADDER_TREE(N),
    .DATA_W(W),
    .N_GROUPS(G),
    .PIX_W(PW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .pix_per_group(pix_per_group),
    .bias_bank(bias_bank),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_group(out_group),
    .out_last(out_last),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [N*W-1:0] data;
    logic           grp;
    logic           last;
  } exp_t;

  typedef struct {
    logic [N*W-1:0] data;
    logic           grp;
    logic           last;
    int             cyc;
  } obs_t;

  exp_t q[$];
  obs_t log_q[$];

  bit   m_run = 0;
  bit   m_busy = 0;
  bit   m_done = 0;
  int   m_ppg = 1;
  int   m_idx = 0;
  int   n_in_fired = 0;
  int   done_count = 0;
  int   done_cyc = -1;
  int   cyc = 0;

  function automatic logic [N*W-1:0] model_beat(input logic [N*W-1:0] din, input int g);
    logic [N*W-1:0]        r;
    logic signed [W-1:0]   lane;
    int                    s;
    r = '0;
    for (int k = 0; k < N; k++) begin
      lane = din[k*W +: W];
      s = int'(lane) + bias_tab[g][k];
      if (s > 131071) s = 131071;
      if (s < -131072) s = -131072;
`ifdef BIAS_RELU_EN
      if (s < 0) s = 0;
`endif
      r[k*W +: W] = W'(s);
    end
    return r;
  endfunction

  function automatic logic [W-1:0] lane_of(input logic [N*W-1:0] v, input int k);
    return v[k*W +: W];
  endfunction

  function automatic logic [W-1:0] relu_lit(input logic [W-1:0] v);
`ifdef BIAS_RELU_EN
    return v[W-1] ? '0 : v;
`else
    return v;
`endif
  endfunction

  function automatic logic [N*W-1:0] mk_in(input int n);
    return {W'(n*1000 - 1500), 18'h20010, 18'h1FF00, 18'd100};
  endfunction

  // Compare process: checks outputs against the model, then advances the model to the next edge.
  always @(negedge clk) begin
    bit   stalled;
    bit   fire;
    bit   start_acc;
    exp_t e;
    cyc++;

    check("out_valid", out_valid, q.size() != 0);
    if (q.size() != 0) begin
      check("out_data", out_data, q[0].data);
      check("out_group", out_group, q[0].grp);
      check("out_last", out_last, q[0].last);
    end
    stalled = (q.size() != 0) && !out_ready;
    check("in_ready", in_ready, m_run && !stalled);
    check("busy", busy, m_busy);
    check("done", done, m_done);

    if (out_valid && out_ready) log_q.push_back('{out_data, out_group[0], out_last, cyc});
    if (done) begin
      done_count++;
      done_cyc = cyc;
    end

    if (rst) begin
      q.delete();
      m_run  = 0;
      m_busy = 0;
      m_done = 0;
    end else begin
      start_acc = !m_busy && start;
      fire      = m_run && in_valid && !stalled;
      m_done    = 0;
      if (q.size() != 0 && out_ready) begin
        if (q[0].last) begin
          m_busy = 0;
          m_done = 1;
        end
        void'(q.pop_front());
      end
      if (fire) begin
        e.data = model_beat(in_data, m_idx / m_ppg);
        e.grp  = 1'((m_idx / m_ppg) != 0);
        e.last = (m_idx == G*m_ppg - 1);
        q.push_back(e);
        if (e.last) m_run = 0;
        m_idx++;
        n_in_fired++;
      end
      if (start_acc) begin
        m_busy = 1;
        m_run  = 1;
        m_idx  = 0;
        m_ppg  = (pix_per_group == 0) ? 1 : int'(pix_per_group);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic begin_layer(input int ppg);
    log_q.delete();
    n_in_fired    = 0;
    in_data       = mk_in(0);
    pix_per_group = PW'(ppg);
    start         = 1'b1;
    tick();
    start         = 1'b0;
  endtask

  task automatic run_until_done(input int budget);
    int d0;
    int c;
    d0 = done_count;
    c  = 0;
    while (done_count == d0 && c < budget) begin
      tick();
      in_data = mk_in(n_in_fired);
      c++;
    end
    check("layer_done_in_budget", done_count != d0, 1'b1);
  endtask

  initial begin
    int c;

    // Reset state
    tick();
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, '0);
    check("rst_out_group", out_group, 1'b0);
    check("rst_out_last", out_last, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_in_ready", in_ready, 1'b0);
    rst = 1'b0;
    tick();

    // Idle input is never accepted
    log_q.delete();
    in_valid = 1'b1;
    in_data  = mk_in(0);
    repeat (3) tick();
    check("idle_in_ready", in_ready, 1'b0);
    check("idle_no_output", log_q.size(), 0);
    in_valid = 1'b0;
    tick();

    // Basic sequence with saturation lanes, ppg=3
    in_valid  = 1'b1;
    out_ready = 1'b1;
    begin_layer(3);
    run_until_done(40);
    in_valid = 1'b0;
    check("basic_count", log_q.size(), 6);
    if (log_q.size() == 6) begin
      check("basic_grp0", log_q[0].grp, 1'b0);
      check("basic_grp2", log_q[2].grp, 1'b0);
      check("basic_grp3", log_q[3].grp, 1'b1);
      check("basic_grp5", log_q[5].grp, 1'b1);
      check("basic_lane0_g0", lane_of(log_q[0].data, 0), relu_lit(18'h3F574));
      check("basic_lane0_g1", lane_of(log_q[3].data, 0), 18'h00187);
      check("sat_pos", lane_of(log_q[1].data, 1), 18'h1FFFF);
      check("sat_neg", lane_of(log_q[4].data, 2), relu_lit(18'h20000));
      check("basic_last4", log_q[4].last, 1'b0);
      check("basic_last5", log_q[5].last, 1'b1);
      check("basic_done_cycle", done_cyc, log_q[5].cyc + 1);
      check("basic_throughput", log_q[5].cyc - log_q[0].cyc, 5);
    end
    tick();

    // Backpressure: out_ready low for several cycles with input pending
    in_valid  = 1'b1;
    out_ready = 1'b0;
    begin_layer(2);
    repeat (6) begin
      tick();
      in_data = mk_in(n_in_fired);
    end
    check("bp_accepted", n_in_fired, 1);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_in_ready", in_ready, 1'b0);
    check("bp_held_lane3", lane_of(out_data, 3), relu_lit(18'h3FA29));
    out_ready = 1'b1;
    run_until_done(40);
    in_valid = 1'b0;
    check("bp_count", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("bp_throughput", log_q[3].cyc - log_q[0].cyc, 3);
      check("bp_lane3_last", lane_of(log_q[3].data, 3), 18'h005D5);
      check("bp_grp2", log_q[2].grp, 1'b1);
    end
    tick();

    // ppg=0 behaves as 1; start during RUN is ignored
    in_valid = 1'b0;
    begin_layer(0);
    tick();
    pix_per_group = 16'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("run_start_busy", busy, 1'b1);
    in_valid = 1'b1;
    run_until_done(40);
    in_valid = 1'b0;
    check("ppg0_count", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("ppg0_grp0", log_q[0].grp, 1'b0);
      check("ppg0_grp1", log_q[1].grp, 1'b1);
      check("ppg0_last0", log_q[0].last, 1'b0);
      check("ppg0_last1", log_q[1].last, 1'b1);
    end
    tick();

    // Reset mid-layer after 4 of 6 beats, then a fresh layer
    in_valid = 1'b1;
    begin_layer(3);
    c = 0;
    while (n_in_fired < 4 && c < 40) begin
      tick();
      in_data = mk_in(n_in_fired);
      c++;
    end
    check("mid_reached_4", n_in_fired, 4);
    rst      = 1'b1;
    in_valid = 1'b0;
    tick();
    rst = 1'b0;
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_in_ready", in_ready, 1'b0);
    tick();
    in_valid = 1'b1;
    begin_layer(3);
    run_until_done(40);
    in_valid = 1'b0;
    check("fresh_count", log_q.size(), 6);
    if (log_q.size() == 6) begin
      check("fresh_grp0", log_q[0].grp, 1'b0);
      check("fresh_grp2", log_q[2].grp, 1'b0);
      check("fresh_grp3", log_q[3].grp, 1'b1);
      check("fresh_last", log_q[5].last, 1'b1);
    end
    repeat (2) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
